// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: pixel/line counters plus registered
// blank, sync, coordinate and line/frame markers for the video pipeline.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POS   = 1'b0,
    parameter bit VS_POS   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        restart,
    output logic        blank,
    output logic        hsync,
    output logic        vsync,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [11:0] pel_x,
    output logic [11:0] pel_y,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Totals may reach 4096, so only the last count is kept in 12 bits.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
    localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
    localparam logic [11:0] H_HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] hcnt;
    logic [11:0] vcnt;
    logic [11:0] hcnt_next;
    logic [11:0] vcnt_next;

    logic blank_next;
    logic hsync_next;
    logic vsync_next;
    logic line_start_next;
    logic frame_start_next;

    // Restart outranks both the increment and the wraps, and ignores ce.
    always_comb begin
        hcnt_next = hcnt;
        vcnt_next = vcnt;
        if (restart) begin
            hcnt_next = '0;
            vcnt_next = '0;
        end else if (ce) begin
            if (hcnt == H_LAST) begin
                hcnt_next = '0;
                if (vcnt == V_LAST) begin
                    vcnt_next = '0;
                end else begin
                    vcnt_next = vcnt + 12'd1;
                end
            end else begin
                hcnt_next = hcnt + 12'd1;
            end
        end
    end

    // Outputs are decoded from the next counter state and registered so they
    // land in the same cycle as the counters they describe.
    always_comb begin
        blank_next       = (hcnt_next >= H_VIS) || (vcnt_next >= V_VIS);
        hsync_next       = (hcnt_next >= H_HS_BEG) && (hcnt_next < H_HS_END);
        vsync_next       = (vcnt_next >= V_VS_BEG) && (vcnt_next < V_VS_END);
        line_start_next  = (hcnt_next == 12'd0);
        frame_start_next = (hcnt_next == 12'd0) && (vcnt_next == 12'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            blank       <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hsync_out   <= ~HS_POS;
            vsync_out   <= ~VS_POS;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            hcnt        <= hcnt_next;
            vcnt        <= vcnt_next;
            blank       <= blank_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            hsync_out   <= HS_POS ? hsync_next : ~hsync_next;
            vsync_out   <= VS_POS ? vsync_next : ~vsync_next;
            line_start  <= line_start_next;
            frame_start <= frame_start_next;
        end
    end

    assign pel_x = hcnt;
    assign pel_y = vcnt;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a linear pixel-index model of the raster checks
// two instances (positive and negative sync pins) under directed and random stimulus.
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;
    logic restart = 1'b0;

    logic        blank_p, hsync_p, vsync_p, hsync_out_p, vsync_out_p, line_start_p, frame_start_p;
    logic [11:0] pel_x_p, pel_y_p;
    logic        blank_n, hsync_n, vsync_n, hsync_out_n, vsync_out_n, line_start_n, frame_start_n;
    logic [11:0] pel_x_n, pel_y_n;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POS(1'b1), .VS_POS(1'b1)
    ) dut_pos (
        .clk(clk), .reset(reset), .ce(ce), .restart(restart),
        .blank(blank_p), .hsync(hsync_p), .vsync(vsync_p),
        .hsync_out(hsync_out_p), .vsync_out(vsync_out_p),
        .pel_x(pel_x_p), .pel_y(pel_y_p),
        .line_start(line_start_p), .frame_start(frame_start_p)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POS(1'b0), .VS_POS(1'b0)
    ) dut_neg (
        .clk(clk), .reset(reset), .ce(ce), .restart(restart),
        .blank(blank_n), .hsync(hsync_n), .vsync(vsync_n),
        .hsync_out(hsync_out_n), .vsync_out(vsync_out_n),
        .pel_x(pel_x_n), .pel_y(pel_y_n),
        .line_start(line_start_n), .frame_start(frame_start_n)
    );

    always #5 clk = ~clk;

    // Model state: position in the frame as a single pixel index.
    int p = 0;
    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll(input string tag);
        int h, v;
        logic eBlank, eHs, eVs;
        h = p % HT;
        v = p / HT;
        eBlank = (h >= HA) || (v >= VA);
        eHs = (h >= HA + HF) && (h < HA + HF + HSW);
        eVs = (v >= VA + VF) && (v < VA + VF + VSW);
        checkOutput({tag, ".pel_x"}, 32'(pel_x_p), 32'(h));
        checkOutput({tag, ".pel_y"}, 32'(pel_y_p), 32'(v));
        checkOutput({tag, ".blank"}, 32'(blank_p), 32'(eBlank));
        checkOutput({tag, ".hsync"}, 32'(hsync_p), 32'(eHs));
        checkOutput({tag, ".vsync"}, 32'(vsync_p), 32'(eVs));
        checkOutput({tag, ".hsync_out"}, 32'(hsync_out_p), 32'(eHs));
        checkOutput({tag, ".vsync_out"}, 32'(vsync_out_p), 32'(eVs));
        checkOutput({tag, ".line_start"}, 32'(line_start_p), 32'(h == 0));
        checkOutput({tag, ".frame_start"}, 32'(frame_start_p), 32'(p == 0));
        checkOutput({tag, ".n.hsync"}, 32'(hsync_n), 32'(eHs));
        checkOutput({tag, ".n.vsync"}, 32'(vsync_n), 32'(eVs));
        checkOutput({tag, ".n.hsync_out"}, 32'(hsync_out_n), 32'(!eHs));
        checkOutput({tag, ".n.vsync_out"}, 32'(vsync_out_n), 32'(!eVs));
        checkOutput({tag, ".n.pel"}, 32'({pel_y_n, pel_x_n}), 32'({12'(v), 12'(h)}));
    endtask

    // One clock: drive at the falling edge, advance the model at the rising
    // edge, then compare just after it.
    task automatic applyStimulus(input logic ceV, input logic restartV);
        @(negedge clk);
        reset = 1'b1;
        ce = ceV;
        restart = restartV;
        @(posedge clk);
        if (restartV) p = 0;
        else if (ceV) p = (p + 1) % FRAME;
        #1;
        compareAll("step");
    endtask

    task automatic assertResetMidCycle(input string tag);
        #2;
        reset = 1'b0;
        p = 0;
        #1;
        compareAll(tag);
    endtask

    initial begin
        int blankRises, vsCount, hsCount, fsCount, hsOutLow, vsOutLow, hsHeld;
        logic prevBlank;

        // Reset applied with no clock edge needed.
        #1 reset = 1'b0;
        #2;
        compareAll("reset");
        checkOutput("reset.hsync_out_n", 32'(hsync_out_n), 32'd1);
        checkOutput("reset.vsync_out_n", 32'(vsync_out_n), 32'd1);
        checkOutput("reset.frame_start", 32'(frame_start_p), 32'd1);

        // Scenario 1: one line after release.
        for (int i = 0; i < HT; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("line1.wrap_x", 32'(pel_x_p), 32'd0);
        checkOutput("line1.wrap_y", 32'(pel_y_p), 32'd1);

        // Scenario 2 and 6: two full frames with event counts.
        applyStimulus(1'b1, 1'b1);
        blankRises = 0; vsCount = 0; hsCount = 0; fsCount = 0; hsOutLow = 0; vsOutLow = 0;
        prevBlank = blank_p;
        for (int i = 0; i < 2 * FRAME; i++) begin
            applyStimulus(1'b1, 1'b0);
            if (blank_p && !prevBlank) blankRises++;
            prevBlank = blank_p;
            if (vsync_p) vsCount++;
            if (hsync_p) hsCount++;
            if (frame_start_p) fsCount++;
            if (!hsync_out_n) hsOutLow++;
            if (!vsync_out_n) vsOutLow++;
        end
        checkOutput("frames.blank_rises", 32'(blankRises), 32'(2 * VA));
        checkOutput("frames.vsync_cycles", 32'(vsCount), 32'(2 * VSW * HT));
        checkOutput("frames.hsync_cycles", 32'(hsCount), 32'(2 * VT * HSW));
        checkOutput("frames.frame_starts", 32'(fsCount), 32'd2);
        checkOutput("frames.hsync_out_n_low", 32'(hsOutLow), 32'(2 * VT * HSW));
        checkOutput("frames.vsync_out_n_low", 32'(vsOutLow), 32'(2 * VSW * HT));

        // Scenario 3: ce alternating, each count visible for two clocks.
        hsHeld = 0;
        for (int i = 0; i < 4 * HT; i++) begin
            applyStimulus(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0);
            if (hsync_p) hsHeld++;
        end
        checkOutput("ce_half.hsync_clks", 32'(hsHeld), 32'(4 * HSW));

        // Scenario 4: restart with ce low, then restart on the double wrap.
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 6 * HT + 5; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("restart.pre_x", 32'(pel_x_p), 32'd5);
        checkOutput("restart.pre_y", 32'(pel_y_p), 32'd6);
        applyStimulus(1'b0, 1'b1);
        checkOutput("restart.x", 32'(pel_x_p), 32'd0);
        checkOutput("restart.y", 32'(pel_y_p), 32'd0);
        checkOutput("restart.frame_start", 32'(frame_start_p), 32'd1);
        checkOutput("restart.vsync", 32'(vsync_p), 32'd0);
        for (int i = 0; i < FRAME - 1; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("restart.corner", 32'({pel_y_p, pel_x_p}), 32'({12'd7, 12'd15}));
        applyStimulus(1'b1, 1'b1);
        checkOutput("restart.corner_xy", 32'({pel_y_p, pel_x_p}), 32'd0);

        // Scenario 5: asynchronous reset between edges at (9,5).
        for (int i = 0; i < 5 * HT + 9; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("areset.pre", 32'({pel_y_p, pel_x_p}), 32'({12'd5, 12'd9}));
        assertResetMidCycle("areset");
        checkOutput("areset.line_start", 32'(line_start_p), 32'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("areset.first_x", 32'(pel_x_p), 32'd1);
        checkOutput("areset.first_y", 32'(pel_y_p), 32'd0);

        // Randomised ce, restart and async reset against the model.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) == 0) assertResetMidCycle("rnd_reset");
            applyStimulus(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Programmable raster timing generator. Produces the blank, hsync and vsync strobes that drive the 5x7 font engine and the overlay stages, plus pixel coordinates and line and frame markers. Sits at the head of the video pipeline, between the pixel clock and the character generator and pixel output. Also drives polarity-corrected sync pins for the display connector.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POS, 0, 1 = hsync_out active-high, 0 = active-low
VS_POS, 0, 1 = vsync_out active-high, 0 = active-low

Ports:
clk  input  1  pixel-domain clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
ce  input  1  pixel enable; counters advance only on clk edges where ce=1
restart  input  1  synchronous frame restart
blank  output  1  1 outside the active area (horizontal or vertical)
hsync  output  1  active-high internal hsync (feeds the font engine)
vsync  output  1  active-high internal vsync (feeds the font engine)
hsync_out  output  1  polarity-corrected hsync pin
vsync_out  output  1  polarity-corrected vsync pin
pel_x  output  12  current horizontal count (hcnt)
pel_y  output  12  current vertical count (vcnt)
line_start  output  1  high while hcnt==0
frame_start  output  1  high while hcnt==0 and vcnt==0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both totals must be ≤4096. Each of the four widths must be ≥1.
- Counters: hcnt counts 0..H_TOTAL-1 and wraps to 0. vcnt increments when hcnt wraps, counts 0..V_TOTAL-1, and wraps to 0.
- Every output is a flop and decodes the current counter state, so outputs stay aligned with the counters (pel_x==hcnt, pel_y==vcnt at every cycle). A combinational path from counters to outputs is not allowed. Implement this by registering the decode of the next-state value.
- blank = (hcnt ≥ H_ACTIVE) | (vcnt ≥ V_ACTIVE). blank stays continuously high across vertical blanking lines, so the font engine sees exactly V_ACTIVE blank rising edges per frame.
- hsync = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines, starting at hcnt=0.
- hsync_out = HS_POS ? hsync : ~hsync. vsync_out = VS_POS ? vsync : ~vsync.
- line_start and frame_start are levels that last one pixel period: one clk when ce is held at 1, and longer when ce is low.
- ce=0: counters and all outputs hold.
- restart=1 on a clk edge: counters load (0,0) regardless of ce. This takes priority over both increment and wrap. Outputs show the (0,0) decode on the next cycle.
- Reset (reset=0, async): hcnt=0, vcnt=0, blank=0, hsync=0, vsync=0, hsync_out=~HS_POS, vsync_out=~VS_POS, pel_x=0, pel_y=0, line_start=1, frame_start=1.
  - All of these are applied immediately, with no clock required.
  - Reset asserted mid-frame aborts the frame.
  - Release is synchronous to clk internally: the first count occurs on the first ce edge after release.
- Simultaneous horizontal and vertical wrap (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, ce=1): next state is (0,0) and frame_start rises.

Test Plan:
(Bench parameters: H 8/2/3/3 giving H_TOTAL=16; V 4/1/2/1 giving V_TOTAL=8; HS_POS=VS_POS=1; ce=1 unless stated.)
1. Release reset, run 16 clks -> pel_x counts 0..15; blank=0 for cycles 0..7 and 1 for 8..15; hsync=1 exactly for hcnt 10..12; line_start=1 at cycles 0 and 16 only.
2. Run 2 frames (256 clks) -> vsync=1 for cycles 80..111 and 208..239; blank constantly 1 for cycles 64..127; exactly 4 blank rising edges per frame; frame_start=1 at cycles 0, 128, 256.
3. ce toggling 1,0,1,0 -> each count held 2 clks; line period is 32 clks; hsync is 6 clks wide; outputs frozen while ce=0.
4. restart pulse at (hcnt=5, vcnt=6), with ce=0 on that edge -> next cycle pel_x=0, pel_y=0, frame_start=1, vsync=0. Also pulse restart at (15,7) -> result is (0,0), with no double increment.
5. Drive reset=0 between clk edges at (9,5) -> outputs go to reset values before the next edge; after release, the first ce edge gives pel_x=1, pel_y=0.
6. HS_POS=0, VS_POS=0 -> hsync_out=0 only for hcnt 10..12 and 1 during reset; vsync_out=0 only on lines 5..6; internal hsync and vsync are unchanged from scenario 2.
